// File: rtl/time_seg_scan_pkg.sv
// Shared constants for the RTC display back-end: segment codes, FSM states, digit count.
// Segment codes are active-low, bit7 = dp (off), bits6:0 = g..a.
package time_seg_scan_pkg;

    localparam int DIG_NUM = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 3'd0;
    localparam fsm_state_t ST_CONV_S = 3'd1;
    localparam fsm_state_t ST_CONV_M = 3'd2;
    localparam fsm_state_t ST_CONV_H = 3'd3;
    localparam fsm_state_t ST_COMMIT = 3'd4;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = SEG_0;
            4'd1:    c = SEG_1;
            4'd2:    c = SEG_2;
            4'd3:    c = SEG_3;
            4'd4:    c = SEG_4;
            4'd5:    c = SEG_5;
            4'd6:    c = SEG_6;
            4'd7:    c = SEG_7;
            4'd8:    c = SEG_8;
            4'd9:    c = SEG_9;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/time_seg_scan_bin2bcd_seq.sv
// Sequential 8-bit binary to 12-bit BCD converter (shift-add-3).
// Latency: start edge loads, then 8 shift edges; done is high during the final shift cycle.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj_d;
    logic [2:0]  cnt_q;
    logic        busy_q;

    always_comb begin
        bcd_adj_d = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {bcd_adj_d[10:0], bin_q, 1'b0};
            cnt_q          <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 3'd7);
    assign bcd  = bcd_q;

endmodule

// File: rtl/time_seg_scan.sv
// Six-digit multiplexed 7-segment driver for h/m/s with per-frame atomic BCD snapshot.
// Outputs registered one clk behind idx; conversion commits 28 clk after the request edge.
module time_seg_scan
    import time_seg_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_MAX = 16'd49_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_dec,
    input  logic [7:0] m_dec,
    input  logic [7:0] h_dec,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic        start_q;
    fsm_state_t  state_q, state_d;
    logic [7:0]  snap_s_q, snap_m_q, snap_h_q;
    logic [11:0] res_s_q, res_m_q;
    logic [11:0] disp_s_q, disp_m_q, disp_h_q;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    logic        wrap, req, take;
    logic        conv_start, conv_busy, conv_done;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic [11:0] field;
    logic [3:0]  nib;

    assign wrap = (cnt_q == SCAN_MAX);
    assign req  = start_q || (wrap && (idx_q == 3'(DIG_NUM - 1)));
    assign take = req && (state_q == ST_IDLE);

    assign conv_start = ((state_q == ST_CONV_S) || (state_q == ST_CONV_M) ||
                         (state_q == ST_CONV_H)) && !conv_busy;

    always_comb begin
        case (state_q)
            ST_CONV_S: conv_bin = snap_s_q;
            ST_CONV_M: conv_bin = snap_m_q;
            default:   conv_bin = snap_h_q;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take)      state_d = ST_CONV_S;
            ST_CONV_S: if (conv_done) state_d = ST_CONV_M;
            ST_CONV_M: if (conv_done) state_d = ST_CONV_H;
            ST_CONV_H: if (conv_done) state_d = ST_COMMIT;
            ST_COMMIT:                state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Odd idx selects the tens nibble of the field.
    always_comb begin
        if (idx_q < 3'd2) begin
            field = disp_s_q;
        end else if (idx_q < 3'd4) begin
            field = disp_m_q;
        end else begin
            field = disp_h_q;
        end
        nib = idx_q[0] ? field[7:4] : field[3:0];

        if (field[11:8] != 4'd0) begin
            seg_d = SEG_DASH;
        end else if ((idx_q == 3'd5) && (nib == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_code(nib);
        end
        if (((idx_q == 3'd2) || (idx_q == 3'd4)) && !disp_s_q[0]) begin
            seg_d[7] = 1'b0;
        end
        sel_d = ~(6'b000001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            start_q  <= 1'b1;
            state_q  <= ST_IDLE;
            snap_s_q <= '0;
            snap_m_q <= '0;
            snap_h_q <= '0;
            res_s_q  <= '0;
            res_m_q  <= '0;
            disp_s_q <= '0;
            disp_m_q <= '0;
            disp_h_q <= '0;
            sel_q    <= 6'b111111;
            seg_q    <= SEG_BLANK;
        end else begin
            cnt_q <= wrap ? 16'd0 : cnt_q + 16'd1;
            if (wrap) begin
                idx_q <= (idx_q == 3'(DIG_NUM - 1)) ? 3'd0 : idx_q + 3'd1;
            end
            if (take) begin
                start_q  <= 1'b0;
                snap_s_q <= s_dec;
                snap_m_q <= m_dec;
                snap_h_q <= h_dec;
            end
            state_q <= state_d;
            // The previous field's result is still in the converter on the next field's load edge.
            if (conv_start && (state_q == ST_CONV_M)) begin
                res_s_q <= conv_bcd;
            end
            if (conv_start && (state_q == ST_CONV_H)) begin
                res_m_q <= conv_bcd;
            end
            if (state_q == ST_COMMIT) begin
                disp_s_q <= res_s_q;
                disp_m_q <= res_m_q;
                disp_h_q <= conv_bcd;
            end
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
